hazard_scoreboard_ctrl: RTL

Issue controller for the decode stage of the 5-stage RV64 pipeline. It tracks in-flight destination registers with a per-register pending-write scoreboard and uses it to stall or release the instruction in decode. It also kills decode slots after a taken branch and drains the pipeline on request for fence and ecall. It replaces ad-hoc EXE/MEM/WB destination compares with one sequential owner of the issue decision.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/src_use_decode.sv | 44 ++++
 rtl/hazard_scoreboard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode constants and issue-controller state encoding for the RV64 decode stage.
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/src_use_decode.sv
// Decodes which register operands an instruction reads and whether it writes rd.
module src_use_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        use_rs1_o,
  output logic        use_rs2_o,
  output logic        wr_rd_o
);

  logic [6:0] opcode;
  logic       rd_nz;
  logic       unused_ir;

  assign opcode    = ir_i[6:0];
  assign rd_nz     = (ir_i[11:7] != 5'd0);
  assign unused_ir = ^ir_i[31:12];

  always_comb begin
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    wr_rd_o   = 1'b0;
    case (opcode)
      OP_OP: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        wr_rd_o   = rd_nz;
      end
      OP_STORE, OP_BRANCH: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        use_rs1_o = 1'b1;
        wr_rd_o   = rd_nz;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        wr_rd_o = rd_nz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage issue controller: pending-write scoreboard, branch flush and fence/ecall drain.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DE_V,
  input  logic [31:0]      DE_IR,
  input  logic             WB_V,
  input  logic [4:0]       WB_DR,
  input  logic             WB_WE,
  input  logic             FLUSH_REQ,
  input  logic             DRAIN_REQ,
  output logic             DE_STALL,
  output logic             EXE_ISSUE,
  output logic             DE_KILL,
  output logic             DRAIN_DONE,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int unsigned PW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PW-1:0] PendMax   = PW'(MAX_INFLIGHT);
  localparam logic [PW-1:0] PendOne   = PW'(1);
  localparam logic [FW-1:0] FlushLoad = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FlushOne  = FW'(1);

  state_e           state_q;
  logic [FW-1:0]    flush_cnt_q;
  logic             drain_done_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [PW-1:0]    pend_q [32];
  logic [PW-1:0]    pend_d [32];

  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, wr_rd;
  logic       hazard, sb_empty, inc_en, dec_en, dec_err;
  logic       de_stall, exe_issue, de_kill;
  logic       unused_ir;

  assign rs1       = DE_IR[19:15];
  assign rs2       = DE_IR[24:20];
  assign rd        = DE_IR[11:7];
  assign unused_ir = ^{DE_IR[31:25], DE_IR[14:12], DE_IR[6:0]};

  src_use_decode u_src_use_decode (
    .ir_i      (DE_IR),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2),
    .wr_rd_o   (wr_rd)
  );

  // No WB bypass: hazards look only at registered pend.
  assign hazard = (use_rs1 && (pend_q[rs1] != '0)) ||
                  (use_rs2 && (pend_q[rs2] != '0)) ||
                  (wr_rd && (pend_q[rd] == PendMax));

  always_comb begin
    sb_empty = 1'b1;
    for (int i = 1; i < 32; i++) begin
      if (pend_q[i] != '0) sb_empty = 1'b0;
    end
  end

  // A flush request squashes the current slot regardless of state.
  always_comb begin
    de_stall  = 1'b0;
    exe_issue = 1'b0;
    de_kill   = 1'b0;
    if (FLUSH_REQ) begin
      de_kill = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          de_stall  = DE_V & hazard;
          exe_issue = DE_V & ~hazard;
        end
        ST_FLUSH: de_kill  = 1'b1;
        ST_DRAIN: de_stall = DE_V;
        default: ;
      endcase
    end
  end

  assign DE_STALL   = de_stall;
  assign EXE_ISSUE  = exe_issue;
  assign DE_KILL    = de_kill;
  assign DRAIN_DONE = drain_done_q;
  assign STALL_CNT  = stall_cnt_q;

  assign inc_en = exe_issue & wr_rd;
  assign dec_en = WB_V & WB_WE & (WB_DR != 5'd0);

  always_comb begin
    for (int i = 0; i < 32; i++) pend_d[i] = pend_q[i];
    dec_err = 1'b0;
    if (!(inc_en && dec_en && (rd == WB_DR))) begin
      if (inc_en) pend_d[rd] = pend_q[rd] + PendOne;
      if (dec_en) begin
        if (pend_q[WB_DR] == '0) dec_err = 1'b1;
        else                     pend_d[WB_DR] = pend_q[WB_DR] - PendOne;
      end
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= '0;
      drain_done_q <= 1'b0;
      stall_cnt_q  <= '0;
      for (int i = 0; i < 32; i++) pend_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
      drain_done_q <= 1'b0;
      if (de_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (FLUSH_REQ) begin
        if (FLUSH_CYCLES > 1) begin
          state_q     <= ST_FLUSH;
          flush_cnt_q <= FlushLoad;
        end else begin
          state_q     <= ST_RUN;
          flush_cnt_q <= '0;
        end
      end else begin
        case (state_q)
          ST_RUN: if (DRAIN_REQ) state_q <= ST_DRAIN;
          ST_FLUSH: begin
            if (flush_cnt_q <= FlushOne) begin
              state_q     <= ST_RUN;
              flush_cnt_q <= '0;
            end else begin
              flush_cnt_q <= flush_cnt_q - FlushOne;
            end
          end
          ST_DRAIN: begin
            if (sb_empty) begin
              state_q      <= ST_RUN;
              drain_done_q <= 1'b1;
            end
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  // Retiring a register with no pending write means the pipeline lost track of it.
  dec_underflow_a : assert property (@(posedge CLK) disable iff (RESET) !dec_err);

endmodule
